// File: rtl/music_sequencer_pkg.sv
// Shared types and song-entry layout for the music sequencer.
package music_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  localparam int unsigned NOTE_MSB = 7;
  localparam int unsigned NOTE_LSB = 4;
  localparam int unsigned DUR_MSB  = 3;
  localparam int unsigned DUR_LSB  = 0;
  localparam int unsigned DUR_W    = DUR_MSB - DUR_LSB + 1;
  // One extra bit so duration+1 (up to 16 beats) fits
  localparam int unsigned BEATS_W  = DUR_W + 1;

  function automatic logic [3:0] entry_note(input logic [7:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [BEATS_W-1:0] entry_beats(input logic [7:0] entry);
    return BEATS_W'(entry[DUR_MSB:DUR_LSB]) + BEATS_W'(1);
  endfunction

endpackage

// File: rtl/music_sequencer_beat_counter.sv
// Remaining-beats down-counter: clear beats load beats decrement.
module beat_counter
  import music_sequencer_pkg::*;
#(
  parameter int unsigned W = BEATS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         expire_c
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Flags the decrement that brings the count to zero
  assign expire_c = dec && (count == W'(1));

endmodule

// File: rtl/music_sequencer.sv
// Song-memory driven note sequencer with play/pause/stop control and optional looping.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int unsigned SONG_LEN = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              beat_tick,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [3:0]        note,
  output logic              playing,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [3:0]          note_nxt;
  logic [3:0]          cur_note, cur_note_nxt;
  logic                cnt_clear, cnt_load, cnt_dec, cnt_expire_c;
  logic [BEATS_W-1:0]  beats_left;
  logic                song_end;

  beat_counter #(.W(BEATS_W)) u_beat_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (entry_beats(mem_data)),
    .dec      (cnt_dec),
    .count    (beats_left),
    .expire_c (cnt_expire_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      note     <= NOTE_REST;
      cur_note <= NOTE_REST;
      playing  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      note     <= note_nxt;
      cur_note <= cur_note_nxt;
      playing  <= (state_nxt == ST_PLAY);
      done     <= (state_nxt == ST_DONE);
    end
  end

  // Next-state logic; priority stop > pause > play
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    note_nxt     = note;
    cur_note_nxt = cur_note;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    song_end     = 1'b0;

    if (stop) begin
      state_nxt = ST_IDLE;
      addr_nxt  = '0;
      note_nxt  = NOTE_REST;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (play) begin
            state_nxt = ST_FETCH;
            addr_nxt  = '0;
          end
        end
        ST_FETCH: state_nxt = ST_LOAD;
        ST_LOAD: begin
          if (entry_note(mem_data) == NOTE_END) begin
            song_end = 1'b1;
          end else begin
            note_nxt     = entry_note(mem_data);
            cur_note_nxt = entry_note(mem_data);
            cnt_load     = 1'b1;
            state_nxt    = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            state_nxt = ST_PAUSE;
            note_nxt  = NOTE_REST;
          end else if (beat_tick) begin
            cnt_dec = 1'b1;
            if (cnt_expire_c) begin
              if (addr != LAST_ADDR) begin
                addr_nxt  = addr + ADDR_W'(1);
                state_nxt = ST_FETCH;
              end else begin
                song_end = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (play) begin
            state_nxt = ST_PLAY;
            note_nxt  = cur_note;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
          note_nxt  = NOTE_REST;
          cnt_clear = 1'b1;
        end
      endcase
    end

    if (song_end) begin
      if (loop_en) begin
        addr_nxt  = '0;
        state_nxt = ST_FETCH;
      end else begin
        state_nxt = ST_DONE;
        note_nxt  = NOTE_REST;
      end
    end
  end

  assign mem_addr = addr;

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter SONG_LEN, default 16: number of song-memory entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 4: song-memory address width; SHALL equal log2(SONG_LEN).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 Port play  input  1  single-cycle pulse: start playback from IDLE or DONE, or resume from PAUSE.
REQ-006 Port pause  input  1  single-cycle pulse: suspend playback, holding position and remaining beats.
REQ-007 Port stop  input  1  single-cycle pulse: abort playback and return to IDLE.
REQ-008 Port loop_en  input  1  level: when high, playback wraps to address 0 instead of finishing.
REQ-009 Port beat_tick  input  1  single-cycle pulse from the external tempo divider; one beat elapses per pulse.
REQ-010 Port mem_addr  output  ADDR_W  song-memory read address.
REQ-011 Port mem_data  input  8  song entry: [7:4] note code, [3:0] duration field; returned one cycle after mem_addr.
REQ-012 Port note  output  4  current note code to the tone generator; 0 = silence.
REQ-013 Port playing  output  1  high in PLAY state only.
REQ-014 Port done  output  1  high in DONE state only.

Function
REQ-015 FSM states: IDLE, FETCH, LOAD, PLAY, PAUSE, DONE.
REQ-016 IDLE: note=0; on play go to FETCH with addr=0.
REQ-017 FETCH: drive mem_addr=addr; next cycle go to LOAD.
REQ-018 LOAD: register mem_data. Note code 0xF is the end marker and triggers end-of-song handling. Any other code loads note and sets beats_left = duration+1, then goes to PLAY.
REQ-019 PLAY: note holds the loaded code; each beat_tick decrements beats_left; the beat_tick that makes beats_left reach 0 triggers advance.
REQ-020 Advance: if addr != SONG_LEN-1, set addr=addr+1 and go to FETCH. If addr == SONG_LEN-1, apply end-of-song handling.
REQ-021 End-of-song: if loop_en is high, set addr=0 and go to FETCH. If loop_en is low, go to DONE with note=0.
REQ-022 Note 0 in an entry is a rest: timed like any note, with silence output.
REQ-023 Latency: a play pulse in IDLE is followed by the first note on the note output exactly 3 cycles later (FETCH, LOAD, PLAY).
REQ-024 During FETCH and LOAD, note SHALL hold its previous value to avoid glitches between notes.
REQ-025 PAUSE: note=0; addr and beats_left are frozen; beat_tick is ignored. play returns to PLAY with the same note and beats_left.
REQ-026 DONE: note=0; done=1; play restarts from addr 0 via FETCH.
REQ-027 pause in IDLE, DONE or PAUSE, and play in PLAY, are ignored.
REQ-028 stop in any state: next state IDLE, note=0, addr=0, beats_left=0.
REQ-029 Simultaneous pulses: stop > pause > play.
REQ-030 A beat_tick coinciding with pause in PLAY is discarded.
REQ-031 beat_tick outside PLAY is ignored; beats are counted only in PLAY.
REQ-032 mem_addr SHALL equal addr in every state.

Reset
REQ-033 reset=0 at a clock edge forces IDLE, addr=0, beats_left=0, note=0, playing=0, done=0; it overrides all other inputs, including mid-note.
REQ-034 The first cycle after reset deasserts is IDLE; play may be accepted in that same cycle.

Structure
REQ-035 A shared package holds the state enum, NOTE_REST=4'h0, NOTE_END=4'hF, and the entry field positions.
REQ-036 The beats_left down-counter (load, decrement on enable, zero flag, clear) is one sub-module named beat_counter; the FSM lives in music_sequencer.

Verification
REQ-037 Mem {0x31,0x50,0xF0}; play; 2 ticks; 1 tick -> note 3 for 2 beats, then 5 for 1 beat, then DONE with done=1 and note=0.
REQ-038 Same mem with loop_en=1; 4 ticks -> after the end marker, mem_addr returns to 0 and note=3 again; done is never 1.
REQ-039 Entry {0x72}; pause after 1 tick; 5 ticks while paused; play -> note=0 while paused; resume with note=7 and 2 beats remaining.
REQ-040 Mid-note, stop together with pause -> IDLE, note=0, mem_addr=0; a following play restarts at entry 0.
REQ-041 reset=0 asserted during PLAY at addr 5 -> next cycle IDLE with all outputs 0; reset held with play pulsing -> stays IDLE.
REQ-042 All 16 entries are non-end with duration 0 -> addr walks 0..15, one beat each, then DONE at addr 15 with no wrap.
